// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: decodes the EX/MEM instruction, runs one req/gnt/rvalid
// bus transaction, stalls the pipeline until it completes and formats the MEM/WB writeback.
module mem_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [31:0] op1_add_op2_res_i,
  input  logic [31:0] reg2_rdata_i,
  input  logic [1:0]  mem_raddr_index_i,
  input  logic [1:0]  mem_waddr_index_i,
  input  logic        reg_we_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic [31:0] reg_wdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_sel_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        hold_req_o,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_nxt;
  logic [15:0] r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic        w_ld, w_st, w_mis, w_mem, w_tmo, w_err;
  logic [1:0]  w_off;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld_data;
  logic        w_unused;

  assign w_unused = ^{inst_i[31:15], inst_i[11:7], op1_add_op2_res_i[1:0]};

  assign w_opc = inst_i[6:0];
  assign w_f3  = inst_i[14:12];
  assign w_ld  = (w_opc == 7'b0000011) &&
                 (w_f3 == 3'b000 || w_f3 == 3'b001 || w_f3 == 3'b010 ||
                  w_f3 == 3'b100 || w_f3 == 3'b101);
  assign w_st  = (w_opc == 7'b0100011) &&
                 (w_f3 == 3'b000 || w_f3 == 3'b001 || w_f3 == 3'b010);
  assign w_off = w_ld ? mem_raddr_index_i : mem_waddr_index_i;
  assign w_mis = (w_ld || w_st) &&
                 (((w_f3[1:0] == 2'b01) && w_off[0]) ||
                  ((w_f3[1:0] == 2'b10) && (w_off != 2'b00)));
  assign w_mem = (w_ld || w_st) && !w_mis;
  assign w_tmo = (r_cnt == TMO_LAST);

  assign mem_addr_o = {op1_add_op2_res_i[31:2], 2'b00};
  assign mem_we_o   = w_st;

  always_comb begin
    mem_sel_o   = 4'b1111;
    mem_wdata_o = reg2_rdata_i;
    case (w_f3[1:0])
      2'b00: begin
        mem_sel_o   = 4'b0001 << w_off;
        mem_wdata_o = {4{reg2_rdata_i[7:0]}};
      end
      2'b01: begin
        mem_sel_o   = w_off[1] ? 4'b1100 : 4'b0011;
        mem_wdata_o = {2{reg2_rdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_byte = mem_rdata_i[{w_off, 3'b000} +: 8];
  assign w_half = w_off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

  always_comb begin
    case (w_f3)
      3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ld_data = {24'b0, w_byte};
      3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_ld_data = {16'b0, w_half};
      default: w_ld_data = mem_rdata_i;
    endcase
  end

  always_comb begin
    w_nxt        = r_state;
    w_err        = 1'b0;
    mem_req_o    = 1'b0;
    hold_req_o   = 1'b0;
    reg_we_o     = 1'b0;
    reg_waddr_o  = 5'b0;
    reg_wdata_o  = 32'b0;
    misaligned_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem) begin
          hold_req_o = 1'b1;
          w_nxt      = S_REQ;
        end else if (w_mis) begin
          misaligned_o = 1'b1;
        end else begin
          reg_we_o    = reg_we_i;
          reg_waddr_o = reg_waddr_i;
          reg_wdata_o = reg_wdata_i;
        end
      end
      S_REQ: begin
        mem_req_o  = 1'b1;
        hold_req_o = 1'b1;
        if (mem_gnt_i) begin
          w_nxt = w_st ? S_DONE : S_WAIT;
        end else if (w_tmo) begin
          w_err = 1'b1;
          w_nxt = S_DONE;
        end
      end
      S_WAIT: begin
        hold_req_o = 1'b1;
        if (mem_rvalid_i) begin
          w_nxt = S_DONE;
        end else if (w_tmo) begin
          w_err = 1'b1;
          w_nxt = S_DONE;
        end
      end
      default: begin
        if (w_ld && !r_err) begin
          reg_we_o    = reg_we_i;
          reg_waddr_o = reg_waddr_i;
          reg_wdata_o = r_rdata;
        end
        w_nxt = S_IDLE;
      end
    endcase
    // Pass-through paths must not leak EX/MEM values while reset is held.
    if (!rst) begin
      mem_req_o    = 1'b0;
      hold_req_o   = 1'b0;
      reg_we_o     = 1'b0;
      reg_waddr_o  = 5'b0;
      reg_wdata_o  = 32'b0;
      misaligned_o = 1'b0;
      w_err        = 1'b0;
    end
  end

  assign bus_err_o = w_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'b0;
      r_rdata <= 32'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_REQ || r_state == S_WAIT) r_cnt <= r_cnt + 16'd1;
      else                                       r_cnt <= 16'b0;
      if (r_state == S_WAIT && mem_rvalid_i) r_rdata <= w_ld_data;
      if (r_state == S_IDLE)  r_err <= 1'b0;
      else if (w_err)         r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: transaction-level model of latency, timeout, strobes and
// load extraction, plus a per-cycle bus monitor.
module tb_mem_lsu;
  localparam int TM = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst;
  logic [31:0] inst_i, op1, reg2, reg_wdata_i, mem_rdata;
  logic [1:0]  ridx, widx;
  logic        reg_we_i, gnt, rvalid;
  logic [4:0]  reg_waddr_i;
  logic        mem_req_o, mem_we_o, hold_req_o, reg_we_o, misaligned_o, bus_err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, reg_wdata_o;
  logic [3:0]  mem_sel_o;
  logic [4:0]  reg_waddr_o;

  int n_chk = 0, n_fail = 0;

  mem_lsu #(.TIMEOUT_CYCLES(TM)) dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .op1_add_op2_res_i(op1), .reg2_rdata_i(reg2),
    .mem_raddr_index_i(ridx), .mem_waddr_index_i(widx), .reg_we_i(reg_we_i),
    .reg_waddr_i(reg_waddr_i), .reg_wdata_i(reg_wdata_i), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_sel_o(mem_sel_o), .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_rdata_i(mem_rdata),
    .hold_req_o(hold_req_o), .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o),
    .reg_wdata_o(reg_wdata_o), .misaligned_o(misaligned_o), .bus_err_o(bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
    return {17'b0, f3, 5'b0, opc};
  endfunction

  // ---- reference model: size in bytes, strobes, replication, extraction ----
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [3:0] m_sel(input logic [2:0] f3, input logic [1:0] off);
    int n = nbytes(f3);
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    logic [31:0] w;
    int n = nbytes(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] rd);
    int n = nbytes(f3);
    logic [31:0] v, mask;
    v = rd >> (8 * off);
    if (n < 4) begin
      mask = (32'd1 << (8 * n)) - 32'd1;
      v = v & mask;
      if (!f3[2] && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic bit m_is_st(input logic [31:0] ins);
    return ins[6:0] == 7'b0100011 && ins[14:12] <= 3'b010;
  endfunction

  // Every cycle the bus is requested, request fields must match the current EX/MEM inputs.
  always @(negedge clk) begin
    if (rst && mem_req_o) begin
      chk("bus_addr", mem_addr_o, {op1[31:2], 2'b00});
      chk("bus_we", 32'(mem_we_o), 32'(m_is_st(inst_i)));
      if (m_is_st(inst_i)) begin
        chk("bus_sel", 32'(mem_sel_o), 32'(m_sel(inst_i[14:12], widx)));
        chk("bus_wdata", mem_wdata_o, m_wdata(inst_i[14:12], reg2));
      end
    end
    if (rst && hold_req_o) chk("no_wb_under_hold", 32'(reg_we_o), 32'd0);
  end

  task automatic access(input logic [31:0] ins, input logic [1:0] off, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [31:0] rd, input int gd,
                        input int rdl, input bit rv_in_gnt,
                        output int hold_n, output int req_n, output bit err,
                        output bit wbwe, output logic [31:0] wbd, output logic [4:0] wba);
    int req_seen = 0, since = 0;
    bit granted = 0, fin = 0;
    hold_n = 0; req_n = 0; err = 0; wbwe = 0; wbd = 0; wba = 0;
    @(posedge clk); #1;
    inst_i = ins; op1 = addr; reg2 = rs2; ridx = off; widx = off;
    reg_we_i = 1'b1; reg_waddr_i = 5'd9; reg_wdata_i = 32'hDEAD_0000;
    for (int k = 0; k < 40 && !fin; k++) begin
      if (k != 0) begin @(posedge clk); #1; end
      gnt = 1'b0; rvalid = 1'b0; mem_rdata = 32'hBADB_AD00;
      if (mem_req_o && !granted && req_seen == gd) begin
        gnt = 1'b1;
        if (rv_in_gnt) begin rvalid = 1'b1; mem_rdata = 32'h5555_5555; end
      end
      if (granted && since == rdl) begin rvalid = 1'b1; mem_rdata = rd; end
      @(negedge clk);
      if (hold_req_o) hold_n++;
      if (mem_req_o) begin req_n++; req_seen++; end
      if (bus_err_o) err = 1;
      if (granted) since++;
      if (gnt) begin granted = 1; since = 1; end
      if (!hold_req_o) begin
        wbwe = reg_we_o; wbd = reg_wdata_o; wba = reg_waddr_o; fin = 1;
      end
    end
    if (!fin) chk("access_bounded", 32'd0, 32'd1);
    @(posedge clk); #1;
    inst_i = NOP; reg_we_i = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    @(negedge clk);
    chk("idle_after_done", 32'({hold_req_o, mem_req_o, bus_err_o}), 32'd0);
  endtask

  // Runs one access and checks it against the latency/timeout rules.
  task automatic run(input string nm, input logic [31:0] ins, input logic [1:0] off,
                     input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rd,
                     input int gd, input int rdl, input bit rv_in_gnt,
                     output int hold_n, output int req_n, output bit err,
                     output logic [31:0] wbd);
    bit ld, e_err, wbwe;
    int e_hold, e_req;
    logic [4:0] wba;
    ld = (ins[6:0] == 7'b0000011);
    e_err = (gd > TM - 1) || (ld && gd < TM - 1 && gd + rdl > TM - 1);
    e_hold = e_err ? 1 + TM : 2 + gd + (ld ? rdl : 0);
    e_req  = (e_err && gd > TM - 1) ? TM : gd + 1;
    access(ins, off, addr, rs2, rd, gd, rdl, rv_in_gnt, hold_n, req_n, err, wbwe, wbd, wba);
    chk({nm, "_hold"}, 32'(hold_n), 32'(e_hold));
    chk({nm, "_req"}, 32'(req_n), 32'(e_req));
    chk({nm, "_err"}, 32'(err), 32'(e_err));
    chk({nm, "_wbwe"}, 32'(wbwe), 32'(ld && !e_err));
    if (ld && !e_err) begin
      chk({nm, "_wbdata"}, wbd, m_load(ins[14:12], off, rd));
      chk({nm, "_wbaddr"}, 32'(wba), 32'd9);
    end
  endtask

  task automatic misalign(input string nm, input logic [31:0] ins, input logic [1:0] off);
    @(posedge clk); #1;
    inst_i = ins; ridx = off; widx = off; reg_we_i = 1'b1; reg_waddr_i = 5'd3;
    @(negedge clk);
    chk({nm, "_pulse"}, 32'(misaligned_o), 32'd1);
    chk({nm, "_quiet"}, 32'({mem_req_o, hold_req_o, reg_we_o}), 32'd0);
    @(posedge clk); #1;
    inst_i = NOP; reg_we_i = 1'b0;
    @(negedge clk);
    chk({nm, "_one_cycle"}, 32'({misaligned_o, mem_req_o}), 32'd0);
  endtask

  initial begin
    int h, r;
    bit e;
    logic [31:0] d;
    rst = 1'b0; inst_i = mk(7'b0000011, 3'b010); op1 = 0; reg2 = 0; ridx = 0; widx = 0;
    reg_we_i = 1'b1; reg_waddr_i = 5'd7; reg_wdata_i = 32'hFFFF_FFFF;
    gnt = 0; rvalid = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({mem_req_o, hold_req_o, reg_we_o, misaligned_o, bus_err_o}), 32'd0);
    chk("reset_wb", {reg_wdata_o[31:5], reg_waddr_o}, 32'd0);
    @(posedge clk); #1; rst = 1'b1; inst_i = NOP; reg_we_i = 1'b0;

    // model pins
    chk("pin_sb_sel", 32'(m_sel(3'b000, 2'd3)), 32'h8);
    chk("pin_sb_wdata", m_wdata(3'b000, 32'hAABBCCDD), 32'hDDDDDDDD);
    chk("pin_lh", m_load(3'b001, 2'd2, 32'h8001_7FFF), 32'hFFFF_8001);
    chk("pin_lbu", m_load(3'b100, 2'd1, 32'h1234_80FF), 32'h0000_0080);

    // non-memory pass-through, including a load opcode with an unused funct3
    @(posedge clk); #1;
    inst_i = NOP; reg_we_i = 1'b1; reg_waddr_i = 5'd5; reg_wdata_i = 32'h1234;
    @(negedge clk);
    chk("pass_we", 32'(reg_we_o), 32'd1);
    chk("pass_waddr", 32'(reg_waddr_o), 32'd5);
    chk("pass_wdata", reg_wdata_o, 32'h1234);
    chk("pass_no_bus", 32'({mem_req_o, hold_req_o}), 32'd0);
    @(posedge clk); #1;
    inst_i = mk(7'b0000011, 3'b011); reg_wdata_i = 32'h5678;
    @(negedge clk);
    chk("ld_f3_011_pass", {reg_wdata_o[30:0], hold_req_o}, {31'h5678, 1'b0});

    // stores
    run("sb", mk(7'b0100011, 3'b000), 2'd3, 32'h1003, 32'hAABBCCDD, 0, 0, 0, 0, h, r, e, d);
    chk("sb_hold_lit", 32'(h), 32'd2);
    run("sh", mk(7'b0100011, 3'b001), 2'd2, 32'h2002, 32'h11223344, 0, 1, 0, 0, h, r, e, d);
    run("sw_gnt_at_limit", mk(7'b0100011, 3'b010), 2'd0, 32'h3000, 32'hCAFEF00D, 0,
        TM - 1, 0, 0, h, r, e, d);

    // loads
    run("lh", mk(7'b0000011, 3'b001), 2'd2, 32'h4002, 0, 32'h8001_7FFF, 3, 2, 0, h, r, e, d);
    chk("lh_lit", d, 32'hFFFF_8001);
    chk("lh_hold_lit", 32'(h), 32'd7);
    run("lhu", mk(7'b0000011, 3'b101), 2'd2, 32'h4002, 0, 32'h8001_7FFF, 3, 2, 1, h, r, e, d);
    chk("lhu_lit", d, 32'h0000_8001);
    run("lb", mk(7'b0000011, 3'b000), 2'd1, 32'h5001, 0, 32'h1234_80FF, 0, 1, 0, h, r, e, d);
    chk("lb_lit", d, 32'hFFFF_FF80);
    run("lbu", mk(7'b0000011, 3'b100), 2'd0, 32'h5000, 0, 32'h1234_80FF, 1, 1, 1, h, r, e, d);
    chk("lbu_lit", d, 32'h0000_00FF);
    run("lw_min", mk(7'b0000011, 3'b010), 2'd0, 32'h6000, 0, 32'h0BAD_F00D, 0, 1, 0, h, r, e, d);
    chk("lw_min_hold_lit", 32'(h), 32'd3);

    // misaligned
    misalign("lw_off1", mk(7'b0000011, 3'b010), 2'd1);
    misalign("sh_off3", mk(7'b0100011, 3'b001), 2'd3);

    // timeouts: in REQ, and in WAIT
    run("tmo_req", mk(7'b0000011, 3'b010), 2'd0, 32'h7000, 0, 0, 1000, 0, 0, h, r, e, d);
    chk("tmo_req_lit", 32'({r[7:0], 7'b0, e}), {8'd4, 7'b0, 1'b1});
    run("tmo_wait", mk(7'b0000011, 3'b010), 2'd0, 32'h7000, 0, 0, 0, 1000, 0, h, r, e, d);

    // reset during WAIT, then a stale rvalid
    @(posedge clk); #1;
    inst_i = mk(7'b0000011, 3'b010); op1 = 32'h8000; ridx = 0; reg_we_i = 1'b1;
    reg_waddr_i = 5'd9;
    @(posedge clk); #1; gnt = 1'b1;
    @(posedge clk); #1; gnt = 1'b0;
    @(negedge clk);
    chk("rst_pre_wait", 32'({hold_req_o, mem_req_o}), 32'h2);
    #1 rst = 1'b0;
    #1 chk("rst_async_outputs",
           32'({mem_req_o, hold_req_o, reg_we_o, misaligned_o, bus_err_o}), 32'd0);
    @(posedge clk); #1; inst_i = NOP; reg_we_i = 1'b0; rst = 1'b1;
    @(posedge clk); #1; rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    chk("stale_rvalid_ignored", 32'({reg_we_o, hold_req_o, mem_req_o}), 32'd0);
    @(posedge clk); #1; rvalid = 1'b0;
    @(negedge clk);
    chk("stale_rvalid_after", 32'({reg_we_o, hold_req_o}), 32'd0);
    run("lw_after_rst", mk(7'b0000011, 3'b010), 2'd0, 32'h9000, 0, 32'h600D_CAFE, 1, 2, 0,
        h, r, e, d);
    chk("lw_after_rst_lit", d, 32'h600D_CAFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "bench timeout");
  end
endmodule
